// File: rtl/myproject_mul_pkg.sv
// Shared constants and arithmetic helpers for the pipelined multiplier / MAC datapath.
// Values travel between stages sign-extended to VAL_W bits before round/saturate.
package myproject_mul_pkg;

  localparam int MODE_MUL = 0;
  localparam int MODE_MAC = 1;
  localparam int VAL_W    = 64;

  // Returns {ovf, result}; result is sign-extended to VAL_W, ties round toward +inf.
  function automatic logic [VAL_W:0] sat_round(input logic signed [VAL_W-1:0] value,
                                               input int shift,
                                               input int width);
    logic signed [VAL_W-1:0] r;
    logic signed [VAL_W-1:0] vmax;
    logic signed [VAL_W-1:0] vmin;
    logic                    o;
    r = value;
    if (shift > 0) begin
      r = (value + (64'sd1 <<< (shift - 1))) >>> shift;
    end
    vmax = (64'sd1 <<< (width - 1)) - 64'sd1;
    vmin = -(64'sd1 <<< (width - 1));
    o    = 1'b0;
    if (r > vmax) begin
      r = vmax;
      o = 1'b1;
    end else if (r < vmin) begin
      r = vmin;
      o = 1'b1;
    end
    return {o, r};
  endfunction

  function automatic bit params_ok(input int w0, input int w1, input int wo, input int ns,
                                   input int sh, input int md, input int wa);
    return (w0 >= 2) && (w1 >= 2) && (w0 + w1 <= 62) &&
           (wo >= 2) && (wo <= 62) &&
           (ns >= 1) && (ns <= 4) &&
           (sh >= 0) && (sh <= w0 + w1 - 1) &&
           ((md == MODE_MUL) || (md == MODE_MAC)) &&
           (wa >= w0 + w1) && (wa <= 62);
  endfunction

endpackage

// File: rtl/myproject_round_sat.sv
// Combinational round-half-up shift and signed saturation of the final pipeline value.
module myproject_round_sat
  import myproject_mul_pkg::*;
#(
  parameter int OUT_WIDTH = 26,
  parameter int SHIFT     = 0
) (
  input  logic signed [VAL_W-1:0]     value_i,
  output logic signed [OUT_WIDTH-1:0] dout_o,
  output logic                        ovf_o
);

  logic [VAL_W:0] res;
  logic           unused_hi;

  assign res       = sat_round(value_i, SHIFT, OUT_WIDTH);
  assign ovf_o     = res[VAL_W];
  assign dout_o    = res[OUT_WIDTH-1:0];
  // Upper bits are only sign copies of dout_o once saturated.
  assign unused_hi = ^res[VAL_W-1:OUT_WIDTH];

endmodule

// File: rtl/myproject_mul_pipe.sv
// Pipelined signed multiplier / multiply-accumulate with stall-all valid/ready handshake.
// Beat accepted at edge k gives out_valid at edge k+NUM_STAGE; out_ready=0 freezes every stage.
module myproject_mul_pipe
  import myproject_mul_pkg::*;
#(
  parameter int din0_WIDTH = 14,
  parameter int din1_WIDTH = 12,
  parameter int dout_WIDTH = 26,
  parameter int NUM_STAGE  = 2,
  parameter int SHIFT      = 0,
  parameter int MODE       = 0,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_last,
  input  logic signed [din0_WIDTH-1:0] din0,
  input  logic signed [din1_WIDTH-1:0] din1,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [dout_WIDTH-1:0] dout,
  output logic                         ovf
);

  localparam int PW = din0_WIDTH + din1_WIDTH;
  localparam int LS = NUM_STAGE - 1;

  if (!params_ok(din0_WIDTH, din1_WIDTH, dout_WIDTH, NUM_STAGE, SHIFT, MODE, ACC_WIDTH)) begin : g_param_err
    $error("myproject_mul_pipe: illegal parameter combination");
  end

  logic                         en;
  logic [NUM_STAGE-1:0]         vld_q;
  logic [NUM_STAGE-1:0]         last_q;
  logic signed [PW-1:0]         prod_q [NUM_STAGE];
  logic signed [PW-1:0]         prod_d;
  logic signed [VAL_W-1:0]      value;
  logic                         emit;
  logic signed [dout_WIDTH-1:0] rs_dout;
  logic                         rs_ovf;
  logic                         out_valid_q, out_valid_d;
  logic signed [dout_WIDTH-1:0] dout_q, dout_d;
  logic                         ovf_q, ovf_d;

  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;
  assign prod_d   = PW'(din0) * PW'(din1);

  // Stage 0 holds the product; later stages are plain retiming registers.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      vld_q  <= '0;
      last_q <= '0;
      for (int i = 0; i < NUM_STAGE; i++) prod_q[i] <= '0;
    end else if (en) begin
      vld_q[0]  <= in_valid;
      last_q[0] <= in_last;
      prod_q[0] <= prod_d;
      for (int i = 1; i < NUM_STAGE; i++) begin
        vld_q[i]  <= vld_q[i-1];
        last_q[i] <= last_q[i-1];
        prod_q[i] <= prod_q[i-1];
      end
    end
  end

  if (MODE == MODE_MAC) begin : g_mac
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d, acc_sum;

    // The emitted sum includes the last beat; the accumulator restarts from zero after it.
    always_comb begin
      acc_sum = acc_q + ACC_WIDTH'(prod_q[LS]);
      acc_d   = acc_q;
      if (en && vld_q[LS]) begin
        acc_d = last_q[LS] ? '0 : acc_sum;
      end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) acc_q <= '0;
      else        acc_q <= acc_d;
    end

    assign value = VAL_W'(acc_sum);
    assign emit  = vld_q[LS] && last_q[LS];
  end else begin : g_mul
    logic unused_last;
    assign unused_last = ^last_q;
    assign value       = VAL_W'(prod_q[LS]);
    assign emit        = vld_q[LS];
  end

  myproject_round_sat #(
    .OUT_WIDTH(dout_WIDTH),
    .SHIFT    (SHIFT)
  ) u_round_sat (
    .value_i(value),
    .dout_o (rs_dout),
    .ovf_o  (rs_ovf)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    ovf_d       = ovf_q;
    if (en) begin
      out_valid_d = emit;
      if (emit) begin
        dout_d = rs_dout;
        ovf_d  = rs_ovf;
      end
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_myproject_mul_pipe.sv
// Scoreboard bench: four configurations (defaults, 16-bit saturating, SHIFT=4, MAC) share one clock/reset.
module tb_myproject_mul_pipe;

  logic ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  logic ap_rst;
  logic vld [4];
  logic lst [4];
  logic ordy [4];
  logic signed [13:0] a [4];
  logic signed [11:0] b [4];
  logic irdy [4];
  logic ovld [4];
  logic ovfw [4];
  logic signed [25:0] d0, d2, d3;
  logic signed [15:0] d1;
  logic signed [25:0] dx [4];

  assign dx[0] = d0;
  assign dx[1] = 26'(d1);
  assign dx[2] = d2;
  assign dx[3] = d3;

  int n_tests = 0;
  int n_fail  = 0;
  logic [26:0] expq [4][$];

  myproject_mul_pipe #(.din0_WIDTH(14), .din1_WIDTH(12), .dout_WIDTH(26), .NUM_STAGE(2),
                       .SHIFT(0), .MODE(0), .ACC_WIDTH(32)) u_def (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(vld[0]), .in_ready(irdy[0]), .in_last(lst[0]),
    .din0(a[0]), .din1(b[0]), .out_valid(ovld[0]), .out_ready(ordy[0]), .dout(d0), .ovf(ovfw[0]));

  myproject_mul_pipe #(.din0_WIDTH(14), .din1_WIDTH(12), .dout_WIDTH(16), .NUM_STAGE(2),
                       .SHIFT(0), .MODE(0), .ACC_WIDTH(32)) u_sat (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(vld[1]), .in_ready(irdy[1]), .in_last(lst[1]),
    .din0(a[1]), .din1(b[1]), .out_valid(ovld[1]), .out_ready(ordy[1]), .dout(d1), .ovf(ovfw[1]));

  myproject_mul_pipe #(.din0_WIDTH(14), .din1_WIDTH(12), .dout_WIDTH(26), .NUM_STAGE(2),
                       .SHIFT(4), .MODE(0), .ACC_WIDTH(32)) u_shf (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(vld[2]), .in_ready(irdy[2]), .in_last(lst[2]),
    .din0(a[2]), .din1(b[2]), .out_valid(ovld[2]), .out_ready(ordy[2]), .dout(d2), .ovf(ovfw[2]));

  myproject_mul_pipe #(.din0_WIDTH(14), .din1_WIDTH(12), .dout_WIDTH(26), .NUM_STAGE(2),
                       .SHIFT(0), .MODE(1), .ACC_WIDTH(32)) u_mac (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(vld[3]), .in_ready(irdy[3]), .in_last(lst[3]),
    .din0(a[3]), .din1(b[3]), .out_valid(ovld[3]), .out_ready(ordy[3]), .dout(d3), .ovf(ovfw[3]));

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  function automatic logic [26:0] E(input logic o, input int d);
    return {o, 26'(d)};
  endfunction

  // Monitors: pop on every accepted result, and require a stalled result to hold.
  for (genvar g = 0; g < 4; g++) begin : g_mon
    logic        held = 1'b0;
    logic [26:0] held_v;
    logic [26:0] cur;
    logic [26:0] want;
    always @(negedge ap_clk) begin
      cur = {ovfw[g], dx[g]};
      if (ap_rst) begin
        held = 1'b0;
      end else begin
        if (held) check($sformatf("hold%0d", g), {36'd0, ovld[g], cur}, {36'd0, 1'b1, held_v});
        held = 1'b0;
        if (ovld[g] && ordy[g]) begin
          if (expq[g].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_out%0d: got 0x%0h, expected no result", g, cur);
          end else begin
            want = expq[g].pop_front();
            check($sformatf("result%0d", g), {37'd0, cur}, {37'd0, want});
          end
        end else if (ovld[g]) begin
          held   = 1'b1;
          held_v = cur;
        end
      end
    end
  end

  task automatic send(input int i, input int av, input int bv, input logic l,
                      input logic has_e, input logic [26:0] e);
    int  n;
    bit  done;
    vld[i] = 1'b1;
    a[i]   = 14'(av);
    b[i]   = 12'(bv);
    lst[i] = l;
    n      = 0;
    done   = 1'b0;
    while (!done) begin
      @(negedge ap_clk);
      if (irdy[i]) begin
        if (has_e) expq[i].push_back(e);
        done = 1'b1;
      end
      @(posedge ap_clk);
      #1;
      n++;
      if (!done && n > 200) begin
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout%0d: in_ready never rose within %0d cycles", i, n);
        vld[i] = 1'b0;
        done   = 1'b1;
      end
    end
  endtask

  task automatic idle(input int i);
    vld[i] = 1'b0;
    lst[i] = 1'b0;
  endtask

  task automatic drain(input int i);
    int n;
    n = 0;
    while (expq[i].size() != 0 && n < 100) begin
      @(posedge ap_clk);
      n++;
    end
    check($sformatf("drain%0d", i), 64'(expq[i].size()), 64'd0);
    repeat (4) @(posedge ap_clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    ap_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vld[i] = 1'b0; lst[i] = 1'b0; ordy[i] = 1'b1; a[i] = '0; b[i] = '0;
    end
    repeat (2) @(negedge ap_clk);
    for (int i = 0; i < 4; i++)
      check($sformatf("reset_state%0d", i), {35'd0, irdy[i], ovld[i], ovfw[i], dx[i]}, {35'd0, 3'b100, 26'd0});
    ap_rst = 1'b0;
    @(posedge ap_clk);
    #1;

    // Default config: extreme negative operands and exact two-cycle latency.
    send(0, -8192, -2048, 1'b0, 1'b1, E(1'b0, 16777216));
    idle(0);
    @(negedge ap_clk); check("lat_edge_k",  64'(ovld[0]), 64'd0);
    @(negedge ap_clk); check("lat_edge_k1", 64'(ovld[0]), 64'd0);
    @(negedge ap_clk); check("lat_edge_k2", 64'(ovld[0]), 64'd1);
    drain(0);

    // 16-bit output: saturation both ways and the exact range edges.
    send(1, 1000, 100, 1'b0, 1'b1, E(1'b1, 32767));
    send(1, -1000, 100, 1'b0, 1'b1, E(1'b1, -32768));
    send(1, 100, 100, 1'b0, 1'b1, E(1'b0, 10000));
    send(1, 128, 256, 1'b0, 1'b1, E(1'b1, 32767));
    send(1, -128, 256, 1'b0, 1'b1, E(1'b0, -32768));
    idle(1);
    drain(1);

    // SHIFT=4: round half toward +inf.
    send(2, 6, 4, 1'b0, 1'b1, E(1'b0, 2));
    send(2, -6, 4, 1'b0, 1'b1, E(1'b0, -1));
    send(2, 2, 4, 1'b0, 1'b1, E(1'b0, 1));
    send(2, -2, 4, 1'b0, 1'b1, E(1'b0, 0));
    send(2, 7, 1, 1'b0, 1'b1, E(1'b0, 0));
    send(2, -9, 1, 1'b0, 1'b1, E(1'b0, -1));
    idle(2);
    drain(2);

    // MAC: one result per group, accumulator restarts after in_last.
    send(3, 3, 4, 1'b0, 1'b0, '0);
    send(3, 5, -2, 1'b0, 1'b0, '0);
    send(3, -1, -1, 1'b1, 1'b1, E(1'b0, 3));
    send(3, 2, 2, 1'b1, 1'b1, E(1'b0, 4));
    idle(3);
    drain(3);

    // Streaming with a 5-cycle downstream stall in the middle.
    fork
      begin
        for (int k = 0; k < 20; k++) begin
          int av;
          int bv;
          av = int'($urandom_range(16383)) - 8192;
          bv = int'($urandom_range(4095)) - 2048;
          send(0, av, bv, 1'b0, 1'b1, E(1'b0, av * bv));
        end
        idle(0);
      end
      begin
        repeat (6) @(posedge ap_clk);
        #1;
        ordy[0] = 1'b0;
        repeat (5) begin
          @(negedge ap_clk);
          check("stall_in_ready", 64'({ovld[0], irdy[0]}), 64'd2);
          @(posedge ap_clk);
          #1;
        end
        ordy[0] = 1'b1;
      end
    join
    drain(0);

    // Reset with two products in flight and a half-summed MAC group.
    fork
      begin
        send(0, 100, 100, 1'b0, 1'b0, '0);
        send(0, -5, 7, 1'b0, 1'b0, '0);
        idle(0);
      end
      begin
        send(3, 7, 7, 1'b0, 1'b0, '0);
        send(3, 2, 2, 1'b0, 1'b0, '0);
        idle(3);
      end
    join
    #2 ap_rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++)
      check($sformatf("reset_mid%0d", i), {35'd0, irdy[i], ovld[i], ovfw[i], dx[i]}, {35'd0, 3'b100, 26'd0});
    repeat (2) @(negedge ap_clk);
    ap_rst = 1'b0;
    @(posedge ap_clk);
    #1;
    send(3, 2, 2, 1'b1, 1'b1, E(1'b0, 4));
    idle(3);
    drain(3);
    drain(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/myproject_mul_pipe.md
# myproject_mul_pipe

Parametrised, pipelined signed multiplier / multiply-accumulate for the dense-layer datapath. It generalises the single-cycle fixed-width multiplier cells to configurable operand widths, pipeline depth, output rounding/saturation and an optional accumulate mode. A valid/ready stream handshake lets it sit between layer buffers with backpressure.

## Interface
- din0_WIDTH, 14, signed operand A width
- din1_WIDTH, 12, signed operand B width
- dout_WIDTH, 26, signed result width after shift/saturate
- NUM_STAGE, 2, pipeline latency in cycles, legal 1..4
- SHIFT, 0, arithmetic right shift applied to product/sum, 0..din0_WIDTH+din1_WIDTH-1
- MODE, 0, 0 = multiply, 1 = multiply-accumulate
- ACC_WIDTH, 32, accumulator width in MODE 1, must be ≥ din0_WIDTH+din1_WIDTH
- ap_clk  in  1  clock, rising edge
- ap_rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts beat this cycle
- in_last  in  1  MODE 1: final beat of an accumulation group; ignored in MODE 0
- din0  in  din0_WIDTH  signed operand A
- din1  in  din1_WIDTH  signed operand B
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- dout  out  dout_WIDTH  signed result
- ovf  out  1  saturation occurred for this result (qualified by out_valid)

## Operation
- Beat accepted when in_valid && in_ready.
- Product P = signed(din0) × signed(din1), full width din0_WIDTH+din1_WIDTH, exact.
- MODE 0: each accepted beat produces one result from P.
- MODE 1: accumulator ACC (ACC_WIDTH, sign-extended adds, wraps silently at ACC_WIDTH) sums P of every beat; on an in_last beat the sum including that beat is emitted and ACC clears to 0 for the next group. Non-last beats produce no output.
- Post-processing on value V (P or group sum): if SHIFT>0, R = (V + 2^(SHIFT-1)) >>> SHIFT (round half toward +∞), else R = V. If R exceeds dout_WIDTH signed range, dout = max/min of that range and ovf = 1; else dout = R, ovf = 0.
- Pipeline is stall-all: global enable en = !out_valid || out_ready; in_ready = en. When en = 0 every stage register, ACC and outputs hold.
- Bubbles (accepted-nothing cycles) propagate as invalid stages; no result is created or dropped.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert at ap_clk): all stage valids 0, out_valid 0, dout 0, ovf 0, ACC 0. in_ready = 1 out of reset.
- Latency: a beat accepted at edge k yields out_valid at edge k+NUM_STAGE when no stall; in MODE 1 counted from the in_last beat.
- Throughput: one beat per cycle while out_ready = 1.
- out_valid/dout/ovf stay stable until out_ready samples 1.
- in_ready combinationally depends on out_ready (single AND/OR level); no other combinational in→out path.
- Simultaneous in_last and stall: beat not accepted, ACC unchanged.
- Reset mid-group or mid-pipeline: in-flight beats and partial ACC discarded; no result emitted.

## Structure
- Shared package myproject_mul_pkg: MODE constants (MODE_MUL, MODE_MAC), function sat_round(value, shift, width) returning {ovf, result}, parameter legality checks.
- Sub-module myproject_round_sat: combinational round/shift/saturate of final stage, instantiated once; rest (product pipeline, ACC, handshake) in the top.
- Product pipelining: multiply in stage 1, remaining NUM_STAGE-1 stages are register retiming stages (balanced by synthesis).

## Test plan
- MODE 0 defaults, din0 = -8192, din1 = -2048 → dout = 16777216, ovf = 0, out_valid exactly NUM_STAGE cycles after accept.
- MODE 0, dout_WIDTH = 16, din0 = 1000, din1 = 100 → dout = 32767, ovf = 1; din0 = -1000 → dout = -32768, ovf = 1.
- MODE 0, SHIFT = 4: P = 24 → dout = 2; P = -24 → dout = -1; P = 8 → dout = 1.
- MODE 1: beats (3,4), (5,-2), (-1,-1, in_last) → single result dout = 3, then group (2,2, in_last) → dout = 4 (ACC cleared).
- Back-to-back 20 random beats, out_ready = 0 for 5 cycles mid-stream → in_ready drops, all 20 results delivered in order, none duplicated, match reference model.
- ap_rst pulsed while 2 beats in flight and MODE 1 group half-summed → outputs reset values immediately, no result emitted, next group sums from 0.
